// File: rtl/branch_hazard_unit.sv
// Branch hazard unit for a 5-stage pipeline that resolves branches in ID.
// Selects forwarding sources for the branch comparator operands and stalls
// the front end when a needed operand is not yet available.
//
// Ports:
//   clk, reset        - clock, asynchronous active-high reset
//   ID_src            - branch source registers, slice i at [i*REG_AW +: REG_AW]
//   ID_isBranch       - instruction in ID is a branch
//   ID_branchTaken    - branch comparator result in ID
//   IDEX_*            - destination register / controls of the EX-stage instruction
//   EXMEM_*           - destination register / controls of the MEM-stage instruction
//   MEMWB_*           - destination register / control of the WB-stage instruction
//   branchFWD         - per-source forward select at [2i +: 2]: 00 RF, 01 EX/MEM, 10 MEM/WB
//   stall             - hold PC and IF/ID, bubble into ID/EX
//   flush_IFID        - squash the fetched instruction after a taken branch
//   stall_cnt         - saturating count of stall cycles (only with BRANCH_STALL_CNT_EN)
//
// Optional feature: define BRANCH_STALL_CNT_EN to add the stall_cnt port and counter.
module branch_hazard_unit #(
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_SRC*REG_AW-1:0]   ID_src,
    input  logic                        ID_isBranch,
    input  logic                        ID_branchTaken,
    input  logic [REG_AW-1:0]           IDEX_rd,
    input  logic                        IDEX_regWrite,
    input  logic                        IDEX_memRead,
    input  logic [REG_AW-1:0]           EXMEM_rd,
    input  logic                        EXMEM_regWrite,
    input  logic                        EXMEM_memRead,
    input  logic [REG_AW-1:0]           MEMWB_rd,
    input  logic                        MEMWB_regWrite,
    output logic [2*NUM_SRC-1:0]        branchFWD,
    output logic                        stall,
    output logic                        flush_IFID
`ifdef BRANCH_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]            stall_cnt
`endif
);

    typedef enum logic {
        IDLE   = 1'b0,
        STALL1 = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [1:0]          need;
    logic [2*NUM_SRC-1:0] fwd_raw;
    logic [REG_AW-1:0]   src;

    // Per-source forwarding select and worst-case stall requirement.
    // A load still in EX costs two cycles; an ALU result in EX or a load
    // in MEM costs one. EX/MEM forwarding excludes loads (data not ready).
    always_comb begin
        need    = 2'd0;
        fwd_raw = '0;
        src     = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            src = ID_src[i*REG_AW +: REG_AW];
            if (EXMEM_regWrite && !EXMEM_memRead && (EXMEM_rd != '0) && (EXMEM_rd == src)) begin
                fwd_raw[2*i +: 2] = 2'b01;
            end else if (MEMWB_regWrite && (MEMWB_rd != '0) && (MEMWB_rd == src)) begin
                fwd_raw[2*i +: 2] = 2'b10;
            end
            if (src != '0) begin
                if (IDEX_memRead && (IDEX_rd == src)) begin
                    need = 2'd2;
                end else if ((need == 2'd0) &&
                             ((IDEX_regWrite && (IDEX_rd == src)) ||
                              (EXMEM_memRead && (EXMEM_rd == src)))) begin
                    need = 2'd1;
                end
            end
        end
        // ID inputs only matter for a branch observed in IDLE.
        if (!ID_isBranch || (state != IDLE)) begin
            need = 2'd0;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and outputs; reset forces all outputs inactive combinationally.
    always_comb begin
        state_nxt  = state;
        stall      = 1'b0;
        branchFWD  = '0;
        flush_IFID = 1'b0;
        case (state)
            IDLE: begin
                if (need == 2'd2) begin
                    state_nxt = STALL1;
                end
                stall = (need != 2'd0);
            end
            STALL1: begin
                state_nxt = IDLE;
                stall     = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (reset) begin
            stall = 1'b0;
        end else if (!stall) begin
            branchFWD  = fwd_raw;
            flush_IFID = ID_isBranch && ID_branchTaken;
        end
    end

`ifdef BRANCH_STALL_CNT_EN
    // Saturating stall-cycle counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: doc/branch_hazard_unit.md
BRANCH_HAZARD_UNIT -- requirements
Module: branch_hazard_unit

Interface
REQ-001 Parameter REG_AW, default 5: register-address width in bits.
REQ-002 Parameter NUM_SRC, default 2: number of branch source operands compared in ID.
REQ-003 Parameter CNT_W, default 16: stall-counter width (used only when BRANCH_STALL_CNT_EN is defined).
REQ-004 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port ID_src, input, NUM_SRC*REG_AW: branch source registers; slice i = bits [i*REG_AW +: REG_AW], slice 0 = rs, slice 1 = rt.
REQ-007 Port ID_isBranch, input, 1: instruction in ID is a branch.
REQ-008 Port ID_branchTaken, input, 1: branch comparator result in ID.
REQ-009 Port IDEX_rd, input, REG_AW; IDEX_regWrite, input, 1; IDEX_memRead, input, 1: destination register and controls in EX.
REQ-010 Port EXMEM_rd, input, REG_AW; EXMEM_regWrite, input, 1; EXMEM_memRead, input, 1: destination register and controls in MEM.
REQ-011 Port MEMWB_rd, input, REG_AW; MEMWB_regWrite, input, 1: destination register and control in WB.
REQ-012 Port branchFWD, output, 2*NUM_SRC: forward select per source at slice [2i +: 2]; 00 = register file, 01 = EX/MEM, 10 = MEM/WB.
REQ-013 Port stall, output, 1: hold PC and IF/ID, insert bubble into ID/EX.
REQ-014 Port flush_IFID, output, 1: squash the fetched instruction after a taken branch.
REQ-015 Port stall_cnt, output, CNT_W: total stall cycles (present only with BRANCH_STALL_CNT_EN).

Function
REQ-016 Forwarding is combinational; per source i: 01 if EXMEM_regWrite && !EXMEM_memRead && EXMEM_rd != 0 && EXMEM_rd == src_i; else 10 if MEMWB_regWrite && MEMWB_rd != 0 && MEMWB_rd == src_i; else 00.
REQ-017 EX/MEM priority over MEM/WB applies identically to every source; no per-source asymmetry.
REQ-018 Hazard "need" (IDLE only, ID_isBranch=1, any source i with src_i != 0): 2 if IDEX_memRead && IDEX_rd == src_i; else 1 if IDEX_regWrite && IDEX_rd == src_i; else 1 if EXMEM_memRead && EXMEM_rd == src_i; else 0.
REQ-019 FSM states: IDLE, STALL1. IDLE -> STALL1 when need == 2; IDLE stays IDLE otherwise; STALL1 -> IDLE unconditionally.
REQ-020 stall = (state == STALL1) || (state == IDLE && need != 0): load-to-branch costs 2 cycles, ALU-to-branch and MEM-load-to-branch cost 1.
REQ-021 While stall = 1, branchFWD is forced to all zeros and flush_IFID = 0.
REQ-022 flush_IFID = ID_isBranch && ID_branchTaken && !stall; a one-cycle combinational pulse.
REQ-023 ID_isBranch = 0 yields need = 0; in STALL1 the ID inputs are ignored for state transitions.
REQ-024 Register 0 never causes forwarding or stall, for any source and stage.

Reset
REQ-025 While reset = 1: state = IDLE, stall = 0, flush_IFID = 0, branchFWD = 0, stall_cnt = 0, regardless of the other inputs.
REQ-026 Reset asserted in STALL1 aborts the stall immediately; after release the FSM starts in IDLE.

Configuration
REQ-027 Macro BRANCH_STALL_CNT_EN defined: stall_cnt increments by 1 on each rising edge where stall = 1 and saturates at all ones.
REQ-028 Macro BRANCH_STALL_CNT_EN undefined: the stall_cnt port and its counter are absent; all other behaviour is unchanged.

Verification
REQ-029 ID_isBranch=1, rs=3, EXMEM_rd=3 regWrite=1 memRead=0, MEMWB_rd=3 regWrite=1 -> branchFWD[1:0]=01, stall=0.
REQ-030 rs=0, EXMEM_rd=0 regWrite=1 -> branchFWD=0, stall=0.
REQ-031 Branch rt=7, IDEX_rd=7 memRead=1 -> stall=1 in cycle 0, state STALL1 and stall=1 in cycle 1, stall=0 in cycle 2; stall_cnt=2 with macro.
REQ-032 Branch rs=4, IDEX_rd=4 regWrite=1 memRead=0 -> stall=1 for exactly one cycle, FSM remains IDLE.
REQ-033 Taken branch with no hazard -> flush_IFID=1 for one cycle; same branch with hazard -> flush_IFID=0 until stall clears.
REQ-034 reset pulsed mid-STALL1 -> stall=0 during reset, FSM IDLE, stall_cnt=0 after release.
